alu_control_md: RTL and testbench



---
 rtl/alu_control_md.sv | 152 +++++++++++++++
 tb/tb_alu_control_md.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_control_md.sv
// EX-stage ALU control: combinational ALUOp/funct decode plus a sequencer that
// launches MULT/MULTU/DIV/DIVU on the mul/div unit and interlocks HI/LO users.
module alu_control_md #(
    parameter int NB_FUNCT    = 6,
    parameter int NB_ALU_OP   = 4,
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32,
    parameter int NB_CNT      = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic                 i_flush,
    input  logic [NB_FUNCT-1:0]  i_op_r_tipe,
    input  logic [NB_ALU_OP-1:0] i_alu_op_CU,
    output logic [NB_FUNCT-1:0]  o_alu_control_signals,
    output logic                 o_stall,
    output logic                 o_md_start,
    output logic [1:0]           o_md_op,
    output logic                 o_hilo_we,
    output logic                 o_busy
);

    localparam logic [NB_ALU_OP-1:0] AOP_ADD   = NB_ALU_OP'(4'b0000);
    localparam logic [NB_ALU_OP-1:0] AOP_ADDU  = NB_ALU_OP'(4'b0001);
    localparam logic [NB_ALU_OP-1:0] AOP_RTYPE = NB_ALU_OP'(4'b0010);
    localparam logic [NB_ALU_OP-1:0] AOP_AND   = NB_ALU_OP'(4'b0100);
    localparam logic [NB_ALU_OP-1:0] AOP_OR    = NB_ALU_OP'(4'b0101);
    localparam logic [NB_ALU_OP-1:0] AOP_SUB   = NB_ALU_OP'(4'b0111);
    localparam logic [NB_ALU_OP-1:0] AOP_XOR   = NB_ALU_OP'(4'b1000);
    localparam logic [NB_ALU_OP-1:0] AOP_SLL   = NB_ALU_OP'(4'b1001);
    localparam logic [NB_ALU_OP-1:0] AOP_SLT   = NB_ALU_OP'(4'b1100);
    localparam logic [NB_ALU_OP-1:0] AOP_SLTU  = NB_ALU_OP'(4'b1101);

    localparam logic [NB_FUNCT-1:0] FN_ADD  = NB_FUNCT'(6'b100000);
    localparam logic [NB_FUNCT-1:0] FN_ADDU = NB_FUNCT'(6'b100001);
    localparam logic [NB_FUNCT-1:0] FN_SUB  = NB_FUNCT'(6'b100010);
    localparam logic [NB_FUNCT-1:0] FN_AND  = NB_FUNCT'(6'b100100);
    localparam logic [NB_FUNCT-1:0] FN_OR   = NB_FUNCT'(6'b100101);
    localparam logic [NB_FUNCT-1:0] FN_XOR  = NB_FUNCT'(6'b100110);
    localparam logic [NB_FUNCT-1:0] FN_SLL  = NB_FUNCT'(6'b000000);
    localparam logic [NB_FUNCT-1:0] FN_SLT  = NB_FUNCT'(6'b101010);
    localparam logic [NB_FUNCT-1:0] FN_SLTU = NB_FUNCT'(6'b101011);

    // Funct groups differ only in the two LSBs: 0110xx = mul/div, 0100xx = MF*/MT*.
    localparam logic [NB_FUNCT-1:0] FN_MD_GRP   = NB_FUNCT'(6'b011000);
    localparam logic [NB_FUNCT-1:0] FN_MFMT_GRP = NB_FUNCT'(6'b010000);

    localparam logic [NB_CNT-1:0] MUL_CNT_INIT = NB_CNT'(MUL_LATENCY - 1);
    localparam logic [NB_CNT-1:0] DIV_CNT_INIT = NB_CNT'(DIV_LATENCY - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic              md_start_q, md_start_d;
    logic [1:0]        md_op_q, md_op_d;
    logic              hilo_we_q, hilo_we_d;
    logic              busy_q, busy_d;

    logic is_rtype;
    logic md_class;
    logic hilo_class;
    logic is_div;
    logic accept;

    always_comb begin
        o_alu_control_signals = FN_ADD;
        case (i_alu_op_CU)
            AOP_RTYPE: o_alu_control_signals = i_op_r_tipe;
            AOP_ADD:   o_alu_control_signals = FN_ADD;
            AOP_ADDU:  o_alu_control_signals = FN_ADDU;
            AOP_AND:   o_alu_control_signals = FN_AND;
            AOP_OR:    o_alu_control_signals = FN_OR;
            AOP_XOR:   o_alu_control_signals = FN_XOR;
            AOP_SLL:   o_alu_control_signals = FN_SLL;
            AOP_SLT:   o_alu_control_signals = FN_SLT;
            AOP_SLTU:  o_alu_control_signals = FN_SLTU;
            AOP_SUB:   o_alu_control_signals = FN_SUB;
            default:   o_alu_control_signals = FN_ADD;
        endcase
    end

    assign is_rtype   = (i_alu_op_CU == AOP_RTYPE);
    assign md_class   = is_rtype && (i_op_r_tipe[NB_FUNCT-1:2] == FN_MD_GRP[NB_FUNCT-1:2]);
    assign hilo_class = md_class ||
                        (is_rtype && (i_op_r_tipe[NB_FUNCT-1:2] == FN_MFMT_GRP[NB_FUNCT-1:2]));
    assign is_div     = i_op_r_tipe[1];

    // A write-back cycle still blocks the accept so the new op never overlaps it.
    assign accept = (state_q == ST_IDLE) && i_valid && md_class && !i_flush && !hilo_we_q;

    assign o_stall = i_valid && hilo_class && ((state_q == ST_BUSY) || hilo_we_q);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            md_start_q <= 1'b0;
            md_op_q    <= 2'b00;
            hilo_we_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            md_start_q <= md_start_d;
            md_op_q    <= md_op_d;
            hilo_we_q  <= hilo_we_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = is_div ? DIV_CNT_INIT : MUL_CNT_INIT;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        md_start_d = accept;
        md_op_d    = accept ? i_op_r_tipe[1:0] : md_op_q;
        hilo_we_d  = (state_q == ST_BUSY) && (cnt_q == '0);
        busy_d     = (state_d == ST_BUSY);
    end

    assign o_md_start = md_start_q;
    assign o_md_op    = md_op_q;
    assign o_hilo_we  = hilo_we_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: per-cycle expectations go into a scoreboard
// queue when inputs are driven and are popped and checked mid-cycle.
module tb_alu_control_md;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic       flush;
    logic [5:0] funct;
    logic [3:0] alu_op;
    logic [5:0] alu_ctl;
    logic       stall;
    logic       md_start;
    logic [1:0] md_op;
    logic       hilo_we;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [5:0] ctl;   // {stall, md_start, md_op[1:0], hilo_we, busy}
        logic [5:0] alu;
    } exp_t;

    exp_t sb[$];

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    alu_control_md dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_valid               (valid),
        .i_flush               (flush),
        .i_op_r_tipe           (funct),
        .i_alu_op_CU           (alu_op),
        .o_alu_control_signals (alu_ctl),
        .o_stall               (stall),
        .o_md_start            (md_start),
        .o_md_op               (md_op),
        .o_hilo_we             (hilo_we),
        .o_busy                (busy)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs, queue the expectation, check at negedge.
    task automatic cyc_full(input string tag, input logic v, input logic f, input logic [5:0] fn,
                            input logic [3:0] aop, input logic rn,
                            input logic [5:0] exp_ctl, input logic [5:0] exp_alu);
        exp_t e;
        logic [5:0] obs_ctl;
        valid  = v;
        flush  = f;
        funct  = fn;
        alu_op = aop;
        rst_n  = rn;
        sb.push_back('{tag, exp_ctl, exp_alu});
        @(negedge clk);
        e = sb.pop_front();
        obs_ctl = {stall, md_start, md_op, hilo_we, busy};
        n_assert++;
        assert (obs_ctl === e.ctl) else begin
            n_fail++;
            $error("FAIL %s ctl{stall,start,op,we,busy} observed=%b expected=%b", e.tag, obs_ctl, e.ctl);
        end
        n_assert++;
        assert (alu_ctl === e.alu) else begin
            n_fail++;
            $error("FAIL %s alu_ctl observed=%b expected=%b", e.tag, alu_ctl, e.alu);
        end
        $display("cycle %s v=%b f=%b fn=%b aop=%b rst_n=%b -> ctl=%b alu=%b", e.tag, v, f, fn, aop, rn,
                 obs_ctl, alu_ctl);
        @(posedge clk);
        #1;
    endtask

    // R-type cycle (ALUOp 0010) or idle cycle (ALUOp 0000, invalid).
    task automatic cyc(input string tag, input logic v, input logic f, input logic [5:0] fn,
                       input logic [5:0] exp_ctl);
        if (v) cyc_full(tag, 1'b1, f, fn, 4'b0010, 1'b1, exp_ctl, fn);
        else   cyc_full(tag, 1'b0, f, 6'b000000, 4'b0000, 1'b1, exp_ctl, 6'b100000);
    endtask

    logic [3:0] sw_op[13];
    logic [5:0] sw_fn[13];
    logic [5:0] sw_exp[13];

    initial begin
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; funct = '0; alu_op = '0;
        @(posedge clk); #1;
        cyc_full("reset_hold", 1'b0, 1'b0, 6'b0, 4'b0000, 1'b0, 6'bxxxxxx === 6'bxxxxxx ? 6'b000000 : 6'b000000, 6'b100000);
        cyc("reset_state", 1'b0, 1'b0, 6'b0, 6'b000000);

        // Decode sweep
        sw_op  = '{4'b0010, 4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1001,
                   4'b1100, 4'b1101, 4'b0111, 4'b1111, 4'b0011, 4'b0010};
        sw_fn  = '{6'b100111, 6'b011000, 6'b011000, 6'b011000, 6'b011000, 6'b011000, 6'b011000,
                   6'b011000, 6'b011000, 6'b011000, 6'b011000, 6'b011000, 6'b010001};
        sw_exp = '{6'b100111, 6'b100000, 6'b100001, 6'b100100, 6'b100101, 6'b100110, 6'b000000,
                   6'b101010, 6'b101011, 6'b100010, 6'b100000, 6'b100000, 6'b010001};
        for (int i = 0; i < 13; i++)
            cyc_full($sformatf("decode_%0d", i), 1'b0, 1'b0, sw_fn[i], sw_op[i], 1'b1, 6'b000000, sw_exp[i]);
        // Non-R-type ALUOp carrying an MD funct must not launch anything
        cyc_full("non_rtype_md", 1'b1, 1'b0, F_MULT, 4'b0000, 1'b1, 6'b000000, 6'b100000);
        cyc("non_rtype_md_after", 1'b0, 1'b0, 6'b0, 6'b000000);
        // MF*/MT* in IDLE: no stall, no state change
        cyc("mfhi_idle", 1'b1, 1'b0, F_MFHI, 6'b000000);
        cyc("mfhi_idle_after", 1'b0, 1'b0, 6'b0, 6'b000000);

        // MULT, latency 4
        cyc("mult_T", 1'b1, 1'b0, F_MULT, 6'b000000);
        cyc("mult_T1", 1'b0, 1'b0, 6'b0, 6'b010001);
        for (int k = 2; k <= 4; k++) cyc($sformatf("mult_T%0d", k), 1'b0, 1'b0, 6'b0, 6'b000001);
        cyc("mult_T5", 1'b0, 1'b0, 6'b0, 6'b000010);
        cyc("mult_T6", 1'b0, 1'b0, 6'b0, 6'b000000);

        // DIVU then MFLO held valid
        cyc("divu_T", 1'b1, 1'b0, F_DIVU, 6'b000000);
        cyc("divu_mflo_T1", 1'b1, 1'b0, F_MFLO, 6'b111101);
        for (int k = 2; k <= 32; k++) cyc($sformatf("divu_mflo_T%0d", k), 1'b1, 1'b0, F_MFLO, 6'b101101);
        cyc("divu_mflo_T33", 1'b1, 1'b0, F_MFLO, 6'b101110);
        cyc("divu_mflo_T34", 1'b1, 1'b0, F_MFLO, 6'b001100);
        cyc("divu_after", 1'b0, 1'b0, 6'b0, 6'b001100);

        // MULT followed by DIV held valid while stalled
        cyc("mdiv_T", 1'b1, 1'b0, F_MULT, 6'b001100);
        cyc("mdiv_T1", 1'b1, 1'b0, F_DIV, 6'b110001);
        for (int k = 2; k <= 4; k++) cyc($sformatf("mdiv_T%0d", k), 1'b1, 1'b0, F_DIV, 6'b100001);
        cyc("mdiv_T5", 1'b1, 1'b0, F_DIV, 6'b100010);
        cyc("mdiv_T6_accept", 1'b1, 1'b0, F_DIV, 6'b000000);
        cyc("mdiv_T7_start", 1'b0, 1'b0, 6'b0, 6'b011001);
        for (int k = 8; k <= 38; k++) cyc($sformatf("mdiv_T%0d", k), 1'b0, 1'b0, 6'b0, 6'b001001);
        cyc("mdiv_T39_we", 1'b0, 1'b0, 6'b0, 6'b001010);
        cyc("mdiv_T40", 1'b0, 1'b0, 6'b0, 6'b001000);

        // Flush in the accept cycle blocks the launch
        cyc("flush_T", 1'b1, 1'b1, F_MULT, 6'b001000);
        cyc("flush_T1", 1'b0, 1'b0, 6'b0, 6'b001000);
        cyc("flush_T2", 1'b0, 1'b0, 6'b0, 6'b001000);
        // Flush during BUSY is ignored; a flushed HILO op still reports stall
        cyc("bflush_T", 1'b1, 1'b0, F_MULT, 6'b001000);
        cyc("bflush_T1", 1'b0, 1'b0, 6'b0, 6'b010001);
        cyc("bflush_T2", 1'b1, 1'b1, F_MFHI, 6'b100001);
        cyc("bflush_T3", 1'b0, 1'b1, 6'b0, 6'b000001);
        cyc("bflush_T4", 1'b0, 1'b0, 6'b0, 6'b000001);
        cyc("bflush_T5", 1'b0, 1'b0, 6'b0, 6'b000010);
        cyc("bflush_T6", 1'b0, 1'b0, 6'b0, 6'b000000);

        // Reset in the middle of a DIV
        cyc("rdiv_T", 1'b1, 1'b0, F_DIV, 6'b000000);
        cyc("rdiv_T1", 1'b0, 1'b0, 6'b0, 6'b011001);
        cyc("rdiv_T2", 1'b0, 1'b0, 6'b0, 6'b001001);
        cyc_full("rdiv_T3_rst", 1'b0, 1'b0, 6'b0, 4'b0000, 1'b0, 6'b001001, 6'b100000);
        cyc("rdiv_T4", 1'b0, 1'b0, 6'b0, 6'b000000);
        cyc("rmult_T5", 1'b1, 1'b0, F_MULT, 6'b000000);
        cyc("rmult_T6", 1'b0, 1'b0, 6'b0, 6'b010001);
        for (int k = 7; k <= 9; k++) cyc($sformatf("rmult_T%0d", k), 1'b0, 1'b0, 6'b0, 6'b000001);
        cyc("rmult_T10", 1'b0, 1'b0, 6'b0, 6'b000010);
        for (int k = 11; k <= 40; k++) cyc($sformatf("rquiet_T%0d", k), 1'b0, 1'b0, 6'b0, 6'b000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
